time_setter: RTL and testbench

Button-driven time/alarm editor that drives the load side of the BCD digital clock, i.e. its hh_in/mm_in/ss_in, load and put_alarm inputs. It debounces four push-buttons and seeds an edit buffer from the running clock's hh/mm/ss. The user steps through the hours, minutes and seconds fields, adjusting each with BCD wrap-around. It then commits the result with a single-cycle load (set time) or put_alarm (arm alarm) pulse.

---
 rtl/time_setter.sv | 204 ++++++++++++++++++++
 tb/tb_time_setter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_setter.sv
// Button-driven time/alarm editor: debounces four buttons, edits a packed-BCD
// hh:mm:ss buffer seeded from the running clock, and commits via load/put_alarm.
module time_setter #(
    parameter logic [15:0] DEBOUNCE     = 16'd50000,
    parameter logic [23:0] REPEAT_DELAY = 24'd5000000,
    parameter logic [23:0] REPEAT_RATE  = 24'd1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_cancel,
    input  logic       alarm_sel,
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic [7:0] ss,
    output logic [7:0] hh_in,
    output logic [7:0] mm_in,
    output logic [7:0] ss_in,
    output logic       load,
    output logic       put_alarm,
    output logic       editing,
    output logic [1:0] field
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EDIT_HH,
        S_EDIT_MM,
        S_EDIT_SS,
        S_COMMIT
    } state_t;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v == top)              return '0;
        else if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
        else                       return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] top);
        if (v == 8'h00)            return top;
        else if (v[3:0] == 4'd0)   return {v[7:4] - 4'd1, 4'd9};
        else                       return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Button bit order: 0 mode, 1 up, 2 down, 3 cancel
    logic [3:0]  raw;
    logic [3:0]  stable_q, stable_dly_q, ev_q;
    logic [15:0] db_cnt_q [4];

    assign raw = {btn_cancel, btn_down, btn_up, btn_mode};

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q     <= '0;
            stable_dly_q <= '0;
            ev_q         <= '0;
            for (int unsigned i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            stable_dly_q <= stable_q;
            ev_q         <= stable_q & ~stable_dly_q;
            for (int unsigned i = 0; i < 4; i++) begin
                if (raw[i] != stable_q[i]) begin
                    if (db_cnt_q[i] == DEBOUNCE - 16'd1) begin
                        stable_q[i] <= raw[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + 16'd1;
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    logic ev_mode, ev_up, ev_down, ev_cancel, held_up, held_dn;
    assign ev_mode   = ev_q[0];
    assign ev_up     = ev_q[1];
    assign ev_down   = ev_q[2];
    assign ev_cancel = ev_q[3];
    assign held_up   = stable_q[1] & ~stable_q[2];
    assign held_dn   = stable_q[2] & ~stable_q[1];

    state_t      state_q, state_d;
    logic        mode_q, mode_d;
    logic [7:0]  hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
    logic [23:0] rpt_cnt_q, rpt_cnt_d;
    logic        rpt_phase_q, rpt_phase_d;
    logic        load_q, put_alarm_q, editing_q;
    logic [1:0]  field_q, field_d;
    logic        step_up, step_dn, rpt_hit;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        hh_d        = hh_q;
        mm_d        = mm_q;
        ss_d        = ss_q;
        rpt_cnt_d   = '0;
        rpt_phase_d = 1'b0;
        step_up     = 1'b0;
        step_dn     = 1'b0;
        rpt_hit     = rpt_phase_q ? (rpt_cnt_q == REPEAT_RATE - 24'd1)
                                  : (rpt_cnt_q == REPEAT_DELAY - 24'd1);

        case (state_q)
            S_IDLE: begin
                if (ev_mode) begin
                    hh_d    = hh;
                    mm_d    = mm;
                    ss_d    = ss;
                    mode_d  = alarm_sel;
                    state_d = S_EDIT_HH;
                end
            end
            S_EDIT_HH, S_EDIT_MM, S_EDIT_SS: begin
                if (ev_cancel) begin
                    state_d = S_IDLE;
                end else begin
                    // Repeat counter only runs with no fresh event and no field change
                    if (ev_up && !ev_down) begin
                        step_up = 1'b1;
                    end else if (ev_down && !ev_up) begin
                        step_dn = 1'b1;
                    end else if (!ev_up && !ev_down && !ev_mode && (held_up || held_dn)) begin
                        if (rpt_hit) begin
                            step_up     = held_up;
                            step_dn     = held_dn;
                            rpt_phase_d = 1'b1;
                        end else begin
                            rpt_cnt_d   = rpt_cnt_q + 24'd1;
                            rpt_phase_d = rpt_phase_q;
                        end
                    end
                    if (ev_mode) begin
                        if (state_q == S_EDIT_HH)      state_d = S_EDIT_MM;
                        else if (state_q == S_EDIT_MM) state_d = S_EDIT_SS;
                        else                           state_d = S_COMMIT;
                    end
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (step_up || step_dn) begin
            case (state_q)
                S_EDIT_HH: hh_d = step_up ? bcd_inc(hh_q, 8'h23) : bcd_dec(hh_q, 8'h23);
                S_EDIT_MM: mm_d = step_up ? bcd_inc(mm_q, 8'h59) : bcd_dec(mm_q, 8'h59);
                S_EDIT_SS: ss_d = step_up ? bcd_inc(ss_q, 8'h59) : bcd_dec(ss_q, 8'h59);
                default: ;
            endcase
        end
    end

    always_comb begin
        field_d = 2'd0;
        case (state_d)
            S_EDIT_HH: field_d = 2'd1;
            S_EDIT_MM: field_d = 2'd2;
            S_EDIT_SS: field_d = 2'd3;
            default:   field_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            hh_q        <= '0;
            mm_q        <= '0;
            ss_q        <= '0;
            rpt_cnt_q   <= '0;
            rpt_phase_q <= 1'b0;
            load_q      <= 1'b0;
            put_alarm_q <= 1'b0;
            editing_q   <= 1'b0;
            field_q     <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            hh_q        <= hh_d;
            mm_q        <= mm_d;
            ss_q        <= ss_d;
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_phase_q <= rpt_phase_d;
            load_q      <= (state_d == S_COMMIT) && !mode_d;
            put_alarm_q <= (state_d == S_COMMIT) && mode_d;
            editing_q   <= (field_d != 2'd0);
            field_q     <= field_d;
        end
    end

    assign hh_in     = hh_q;
    assign mm_in     = mm_q;
    assign ss_in     = ss_q;
    assign load      = load_q;
    assign put_alarm = put_alarm_q;
    assign editing   = editing_q;
    assign field     = field_q;

endmodule

// File: tb/tb_time_setter.sv
// Self-checking bench for time_setter: randomized button sessions checked against
// a decimal-arithmetic model of the edit buffer, field and commit pulses.
module tb_time_setter;

    localparam logic [15:0] DB = 16'd4;
    localparam logic [23:0] RD = 24'd10;
    localparam logic [23:0] RR = 24'd3;
    localparam int HOLD = 7;
    localparam int REL  = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn = '0;   // 0 mode, 1 up, 2 down, 3 cancel
    logic       alarm_sel = 1'b0;
    logic [7:0] hh = '0, mm = '0, ss = '0;
    logic [7:0] hh_in, mm_in, ss_in;
    logic       load, put_alarm, editing;
    logic [1:0] field;

    time_setter #(.DEBOUNCE(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn[0]), .btn_up(btn[1]), .btn_down(btn[2]), .btn_cancel(btn[3]),
        .alarm_sel(alarm_sel), .hh(hh), .mm(mm), .ss(ss),
        .hh_in(hh_in), .mm_in(mm_in), .ss_in(ss_in),
        .load(load), .put_alarm(put_alarm), .editing(editing), .field(field)
    );

    always #5 clk = ~clk;

    int ntests = 0, nfail = 0;
    int load_cnt = 0, pa_cnt = 0, both_cnt = 0;
    logic [23:0] commit_val = '0;

    always @(negedge clk) begin
        if (load) load_cnt++;
        if (put_alarm) pa_cnt++;
        if (load && put_alarm) both_cnt++;
        if (load || put_alarm) commit_val = {hh_in, mm_in, ss_in};
    end

    // Reference model: plain decimal values, field index 0..3, latched alarm bit
    int m_h, m_m, m_s, m_field;
    bit m_alarm;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int wrap_step(input int v, input int modn, input bit up);
        return up ? (v + 1) % modn : (v + modn - 1) % modn;
    endfunction

    function automatic logic [23:0] model_buf();
        return {to_bcd(m_h), to_bcd(m_m), to_bcd(m_s)};
    endfunction

    task automatic model_step(input bit up);
        case (m_field)
            1: m_h = wrap_step(m_h, 24, up);
            2: m_m = wrap_step(m_m, 60, up);
            3: m_s = wrap_step(m_s, 60, up);
            default: ;
        endcase
    endtask

    task automatic model_mode();
        m_field = (m_field == 3) ? 0 : m_field + 1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] b);
        btn = b;
        tick(HOLD);
        btn = '0;
        tick(REL);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hh = to_bcd(h); mm = to_bcd(m); ss = to_bcd(s);
    endtask

    task automatic enter_edit(input int h, input int m, input int s, input bit asel);
        set_time(h, m, s);
        alarm_sel = asel;
        press(4'b0001);
        m_h = h; m_m = m; m_s = s; m_field = 1; m_alarm = asel;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        ntests++;
        if ({hh_in, mm_in, ss_in, load, put_alarm, editing, field} !== 29'd0) begin
            nfail++;
            $display("FAIL reset_state got %h/%h/%h l=%b p=%b e=%b f=%0d want all zero",
                     hh_in, mm_in, ss_in, load, put_alarm, editing, field);
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_seed_commit();
        int lc, pc;
        enter_edit(12, 34, 56, 1'b0);
        ntests++;
        if ({editing, field, hh_in, mm_in, ss_in} !== {1'b1, 2'd1, 24'h123456}) begin
            nfail++;
            $display("FAIL seed got e=%b f=%0d %h%h%h want e=1 f=1 123456", editing, field, hh_in, mm_in, ss_in);
        end
        press(4'b0001); press(4'b0001);
        ntests++;
        if (field !== 2'd3) begin
            nfail++;
            $display("FAIL seed_field got %0d want 3", field);
        end
        lc = load_cnt; pc = pa_cnt;
        press(4'b0001);
        ntests++;
        if ((load_cnt - lc) != 1 || (pa_cnt - pc) != 0 || commit_val !== 24'h123456) begin
            nfail++;
            $display("FAIL seed_commit got load=%0d pa=%0d val=%h want 1 0 123456",
                     load_cnt - lc, pa_cnt - pc, commit_val);
        end
        ntests++;
        if ({editing, field, hh_in, mm_in, ss_in} !== {1'b0, 2'd0, 24'h123456}) begin
            nfail++;
            $display("FAIL seed_idle got e=%b f=%0d %h%h%h want e=0 f=0 123456", editing, field, hh_in, mm_in, ss_in);
        end
    endtask

    task automatic test_wrap();
        int lc;
        enter_edit(23, 59, 0, 1'b0);
        press(4'b0010); model_step(1);
        ntests++;
        if (hh_in !== 8'h00 || {hh_in, mm_in, ss_in} !== model_buf()) begin
            nfail++;
            $display("FAIL wrap_hh_up got %h want 00", hh_in);
        end
        press(4'b0001); model_mode();
        press(4'b0010); model_step(1);
        press(4'b0100); model_step(0);
        ntests++;
        if (mm_in !== 8'h59 || {hh_in, mm_in, ss_in} !== model_buf()) begin
            nfail++;
            $display("FAIL wrap_mm_down got %h want 59", mm_in);
        end
        for (int i = 0; i < 11; i++) begin press(4'b0010); model_step(1); end
        ntests++;
        if ({hh_in, mm_in, ss_in} !== model_buf()) begin
            nfail++;
            $display("FAIL wrap_mm_run got %h%h%h want %h", hh_in, mm_in, ss_in, model_buf());
        end
        press(4'b0100); model_step(0);
        ntests++;
        if (mm_in !== 8'h09 || {hh_in, mm_in, ss_in} !== model_buf()) begin
            nfail++;
            $display("FAIL wrap_mm_borrow got %h want 09", mm_in);
        end
        press(4'b0001); model_mode();
        for (int i = 0; i < 9; i++) begin press(4'b0010); model_step(1); end
        press(4'b0010); model_step(1);
        ntests++;
        if (ss_in !== 8'h10 || {hh_in, mm_in, ss_in} !== model_buf()) begin
            nfail++;
            $display("FAIL wrap_ss_carry got %h want 10", ss_in);
        end
        lc = load_cnt;
        press(4'b0001); model_mode();
        ntests++;
        if ((load_cnt - lc) != 1 || commit_val !== model_buf()) begin
            nfail++;
            $display("FAIL wrap_commit got load=%0d val=%h want 1 %h", load_cnt - lc, commit_val, model_buf());
        end
    endtask

    task automatic test_alarm();
        int lc, pc;
        enter_edit($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59), 1'b1);
        alarm_sel = 1'b0;
        press(4'b0010); model_step(1);
        lc = load_cnt; pc = pa_cnt;
        press(4'b0001); press(4'b0001); press(4'b0001);
        ntests++;
        if ((pa_cnt - pc) != 1 || (load_cnt - lc) != 0 || commit_val !== model_buf()) begin
            nfail++;
            $display("FAIL alarm_commit got pa=%0d load=%0d val=%h want 1 0 %h",
                     pa_cnt - pc, load_cnt - lc, commit_val, model_buf());
        end
    endtask

    task automatic test_cancel();
        int lc, pc;
        enter_edit($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59), 1'b0);
        press(4'b0001); model_mode();
        press(4'b0010); model_step(1);
        lc = load_cnt; pc = pa_cnt;
        press(4'b1001);
        ntests++;
        if (editing !== 1'b0 || field !== 2'd0 || (load_cnt - lc) != 0 || (pa_cnt - pc) != 0
            || {hh_in, mm_in, ss_in} !== model_buf()) begin
            nfail++;
            $display("FAIL cancel got e=%b f=%0d load=%0d buf=%h want 0 0 0 %h",
                     editing, field, load_cnt - lc, {hh_in, mm_in, ss_in}, model_buf());
        end
        press(4'b0010); press(4'b0100); press(4'b1000);
        ntests++;
        if (editing !== 1'b0 || {hh_in, mm_in, ss_in} !== model_buf()) begin
            nfail++;
            $display("FAIL idle_ignore got e=%b buf=%h want 0 %h", editing, {hh_in, mm_in, ss_in}, model_buf());
        end
    endtask

    task automatic test_simultaneous();
        enter_edit($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59), 1'b0);
        press(4'b0110);
        ntests++;
        if ({hh_in, mm_in, ss_in} !== model_buf()) begin
            nfail++;
            $display("FAIL up_down_together got %h want %h", {hh_in, mm_in, ss_in}, model_buf());
        end
        press(4'b0011); model_step(1); model_mode();
        ntests++;
        if (field !== 2'(m_field) || {hh_in, mm_in, ss_in} !== model_buf()) begin
            nfail++;
            $display("FAIL mode_with_up got f=%0d buf=%h want f=%0d %h", field, {hh_in, mm_in, ss_in}, m_field, model_buf());
        end
        press(4'b1000);
    endtask

    // Steps while a button stays stable for W cycles after its press event
    function automatic int rpt_steps(input int w);
        return 1 + ((w >= int'(RD)) ? 1 + (w - int'(RD)) / int'(RR) : 0);
    endfunction

    task automatic test_repeat();
        int h, n;
        bit up;
        enter_edit($urandom_range(0, 23), 0, $urandom_range(0, 59), 1'b0);
        press(4'b0001); model_mode();
        // raw held 20 cycles past the event; stable lingers DB-1 more after release
        btn = 4'b0010;
        tick(int'(DB) + 1 + 20);
        btn = '0;
        tick(REL + 10);
        n = rpt_steps(20 + int'(DB) - 1);
        for (int i = 0; i < n; i++) model_step(1);
        ntests++;
        if (mm_in !== 8'h06 || {hh_in, mm_in, ss_in} !== model_buf()) begin
            nfail++;
            $display("FAIL repeat_fixed got mm=%h want 06", mm_in);
        end
        for (int k = 0; k < 4; k++) begin
            h = $urandom_range(0, 20);
            up = 1'($urandom_range(0, 1));
            btn = up ? 4'b0010 : 4'b0100;
            tick(int'(DB) + 1 + h);
            btn = '0;
            tick(REL + 10);
            n = rpt_steps(h + int'(DB) - 1);
            for (int i = 0; i < n; i++) model_step(up);
            ntests++;
            if ({hh_in, mm_in, ss_in} !== model_buf()) begin
                nfail++;
                $display("FAIL repeat_rand h=%0d up=%b got %h want %h", h, up, {hh_in, mm_in, ss_in}, model_buf());
            end
        end
        press(4'b1000);
    endtask

    task automatic test_random();
        int r, lc, pc;
        for (int sess = 0; sess < 5; sess++) begin
            enter_edit($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59),
                       1'($urandom_range(0, 1)));
            for (int op = 0; op < 10; op++) begin
                r = $urandom_range(0, 6);
                if ((r == 4 || r == 6) && m_field == 3) r = 0;
                case (r)
                    0, 1: begin press(4'b0010); model_step(1); end
                    2, 3: begin press(4'b0100); model_step(0); end
                    4:    begin press(4'b0001); model_mode(); end
                    5:    press(4'b0110);
                    default: begin press(4'b0101); model_step(0); model_mode(); end
                endcase
                ntests++;
                if (field !== 2'(m_field) || {hh_in, mm_in, ss_in} !== model_buf()) begin
                    nfail++;
                    $display("FAIL random_op s=%0d op=%0d r=%0d got f=%0d %h want f=%0d %h",
                             sess, op, r, field, {hh_in, mm_in, ss_in}, m_field, model_buf());
                end
            end
            lc = load_cnt; pc = pa_cnt;
            if ($urandom_range(0, 3) == 0) begin
                press(4'b1000);
                ntests++;
                if ((load_cnt - lc) != 0 || (pa_cnt - pc) != 0 || editing !== 1'b0) begin
                    nfail++;
                    $display("FAIL random_cancel got load=%0d pa=%0d e=%b want 0 0 0", load_cnt - lc, pa_cnt - pc, editing);
                end
            end else begin
                while (m_field != 0) begin press(4'b0001); model_mode(); end
                ntests++;
                if ((load_cnt - lc) != (m_alarm ? 0 : 1) || (pa_cnt - pc) != (m_alarm ? 1 : 0)
                    || commit_val !== model_buf()) begin
                    nfail++;
                    $display("FAIL random_commit alarm=%b got load=%0d pa=%0d val=%h want val=%h",
                             m_alarm, load_cnt - lc, pa_cnt - pc, commit_val, model_buf());
                end
            end
        end
    endtask

    task automatic test_glitch();
        btn = 4'b0001;
        tick(3);
        btn = '0;
        tick(12);
        ntests++;
        if (editing !== 1'b0 || field !== 2'd0) begin
            nfail++;
            $display("FAIL glitch_mode got e=%b f=%0d want 0 0", editing, field);
        end
        enter_edit($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59), 1'b0);
        btn = 4'b0010;
        tick(3);
        btn = '0;
        tick(12);
        ntests++;
        if ({hh_in, mm_in, ss_in} !== model_buf()) begin
            nfail++;
            $display("FAIL glitch_up got %h want %h", {hh_in, mm_in, ss_in}, model_buf());
        end
        press(4'b1000);
    endtask

    task automatic test_reset_commit();
        int lc, pc;
        enter_edit(12, 34, 56, 1'b0);
        press(4'b0001); press(4'b0001);
        lc = load_cnt; pc = pa_cnt;
        btn = 4'b0001;
        tick(int'(DB));
        reset = 1'b1;
        btn = '0;
        tick(1);
        ntests++;
        if ({hh_in, mm_in, ss_in, load, put_alarm, editing, field} !== 29'd0) begin
            nfail++;
            $display("FAIL reset_commit_state got %h%h%h l=%b p=%b e=%b f=%0d want all zero",
                     hh_in, mm_in, ss_in, load, put_alarm, editing, field);
        end
        tick(3);
        reset = 1'b0;
        tick(REL + 5);
        ntests++;
        if ((load_cnt - lc) != 0 || (pa_cnt - pc) != 0 || editing !== 1'b0
            || {hh_in, mm_in, ss_in} !== 24'h0) begin
            nfail++;
            $display("FAIL reset_commit_pulse got load=%0d pa=%0d e=%b buf=%h want 0 0 0 000000",
                     load_cnt - lc, pa_cnt - pc, editing, {hh_in, mm_in, ss_in});
        end
    endtask

    task automatic test_exclusive();
        ntests++;
        if (both_cnt != 0) begin
            nfail++;
            $display("FAIL pulse_exclusive got %0d overlapping cycles want 0", both_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_seed_commit();
        test_wrap();
        test_alarm();
        test_cancel();
        test_simultaneous();
        test_repeat();
        test_random();
        test_glitch();
        test_reset_commit();
        test_exclusive();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
